// File: rtl/iterative_multiplier_if.sv
// Handshake and result bundle between the EX-stage controller and the
// iterative MULT/MULTU unit.
interface iterative_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start,
        output is_signed,
        output operand_a,
        output operand_b,
        input  busy,
        input  done,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  is_signed,
        input  operand_a,
        input  operand_b,
        output busy,
        output done,
        output hi,
        output lo
    );
endinterface

// File: rtl/iterative_multiplier.sv
// Shift-add multiplier for MIPS MULT/MULTU: one WIDTH-bit add per cycle on
// operand magnitudes, sign applied once at the end, product held in HI/LO.
module iterative_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    iterative_multiplier_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    // Two's complement magnitude; the most negative value maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic             signed_mode);
        logic [WIDTH-1:0] result;
        if (signed_mode && value[WIDTH-1]) begin
            result = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] value);
        return ~value + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]       state_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic             carry_r;
    logic             neg_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [1:0]         state_s;
    logic [WIDTH-1:0]   mcand_s;
    logic [WIDTH-1:0]   acc_hi_s;
    logic [WIDTH-1:0]   acc_lo_s;
    logic               carry_s;
    logic               neg_s;
    logic [CW-1:0]      count_s;
    logic               busy_s;
    logic               done_s;
    logic [WIDTH-1:0]   hi_s;
    logic [WIDTH-1:0]   lo_s;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH:0]   shifted_s;
    logic [2*WIDTH-1:0] product_s;
    logic [2*WIDTH-1:0] signed_product_s;

    // Datapath: the single adder step, the shifted accumulator and the sign fix-up.
    always_comb begin
        addend_s         = acc_lo_r[0] ? mcand_r : {WIDTH{1'b0}};
        sum_s            = {carry_r, acc_hi_r} + {1'b0, addend_s};
        shifted_s        = {sum_s, acc_lo_r} >> 1;
        product_s        = {acc_hi_r, acc_lo_r};
        signed_product_s = neg_r ? negate_wide(product_s) : product_s;
    end

    // Next-state and next-register values for the IDLE -> RUN -> FIX sequence.
    always_comb begin
        state_s  = state_r;
        mcand_s  = mcand_r;
        acc_hi_s = acc_hi_r;
        acc_lo_s = acc_lo_r;
        carry_s  = carry_r;
        neg_s    = neg_r;
        count_s  = count_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        hi_s     = hi_r;
        lo_s     = lo_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_s  = magnitude(bus.operand_a, bus.is_signed);
                    acc_lo_s = magnitude(bus.operand_b, bus.is_signed);
                    acc_hi_s = {WIDTH{1'b0}};
                    carry_s  = 1'b0;
                    neg_s    = bus.is_signed & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                    count_s  = {CW{1'b0}};
                    busy_s   = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                {carry_s, acc_hi_s, acc_lo_s} = shifted_s;
                count_s = count_r + COUNT_ONE;
                if (count_r == COUNT_LAST) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIX: begin
                {hi_s, lo_s} = signed_product_s;
                done_s       = 1'b1;
                busy_s       = 1'b0;
                state_s      = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            mcand_r  <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            neg_r    <= 1'b0;
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            state_r  <= state_s;
            mcand_r  <= mcand_s;
            acc_hi_r <= acc_hi_s;
            acc_lo_r <= acc_lo_s;
            carry_r  <= carry_s;
            neg_r    <= neg_s;
            count_r  <= count_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed and reference-checked bench for iterative_multiplier (WIDTH=32).
module tb_iterative_multiplier;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    iterative_multiplier_if #(.WIDTH(32)) mul_if ();

    iterative_multiplier #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mul_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from an idle unit and wait (bounded) for done.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r_hi, output logic [31:0] r_lo, output int cyc);
        mul_if.is_signed = sgn;
        mul_if.operand_a = a;
        mul_if.operand_b = b;
        mul_if.start     = 1'b1;
        @(posedge clk); #1;
        mul_if.start     = 1'b0;
        mul_if.operand_a = ~a;
        mul_if.operand_b = ~b;
        mul_if.is_signed = ~sgn;
        cyc = 0;
        while (mul_if.done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        r_hi = mul_if.hi;
        r_lo = mul_if.lo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mul_if.start = 1'b0;
        mul_if.is_signed = 1'b0;
        mul_if.operand_a = 32'd0;
        mul_if.operand_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({mul_if.busy, mul_if.done, mul_if.hi, mul_if.lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     mul_if.busy, mul_if.done, mul_if.hi, mul_if.lo);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multu_max();
        logic [31:0] h, l;
        int cyc;
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, cyc);
        tests_run++;
        if ({h, l} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin
            tests_failed++;
            $display("FAIL multu_max got %h_%h want fffffffe_00000001", h, l);
        end
        tests_run++;
        if (cyc !== 33) begin
            tests_failed++;
            $display("FAIL multu_latency got %0d want 33", cyc);
        end
        tests_run++;
        if (mul_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_in_done_cycle got %b want 0", mul_if.busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (mul_if.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_single_pulse got %b want 0", mul_if.done);
        end
    endtask

    task automatic test_signed();
        logic [31:0] h, l;
        int cyc;
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5, h, l, cyc);
        tests_run++;
        if ({h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
            tests_failed++;
            $display("FAIL mult_neg3x5 got %h_%h want ffffffff_fffffff1", h, l);
        end
        run_op(1'b1, 32'h8000_0000, 32'd1, h, l, cyc);
        tests_run++;
        if ({h, l} !== {32'hFFFF_FFFF, 32'h8000_0000}) begin
            tests_failed++;
            $display("FAIL mult_min_x1 got %h_%h want ffffffff_80000000", h, l);
        end
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, h, l, cyc);
        tests_run++;
        if ({h, l} !== {32'h4000_0000, 32'h0000_0000}) begin
            tests_failed++;
            $display("FAIL mult_min_sq got %h_%h want 40000000_00000000", h, l);
        end
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, h, l, cyc);
        tests_run++;
        if ({h, l} !== {32'h4000_0000, 32'h0000_0000}) begin
            tests_failed++;
            $display("FAIL multu_min_sq got %h_%h want 40000000_00000000", h, l);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int busy_cnt;
        mul_if.is_signed = 1'b0;
        mul_if.operand_a = 32'd1000;
        mul_if.operand_b = 32'd3000;
        mul_if.start     = 1'b1;
        @(posedge clk); #1;
        mul_if.start = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (mul_if.done !== 1'b1 && cyc < 100) begin
            if (mul_if.busy === 1'b1) busy_cnt++;
            if (cyc == 5 || cyc == 20) begin
                mul_if.start     = 1'b1;
                mul_if.is_signed = 1'b1;
                mul_if.operand_a = 32'hFFFF_FFF9;
                mul_if.operand_b = 32'd7;
            end else begin
                mul_if.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (busy_cnt !== 33 || cyc !== 33) begin
            tests_failed++;
            $display("FAIL busy_ignore_start got busy=%0d done_at=%0d want 33 33", busy_cnt, cyc);
        end
        tests_run++;
        if ({mul_if.hi, mul_if.lo} !== {32'd0, 32'd3000000}) begin
            tests_failed++;
            $display("FAIL first_op_kept got %h_%h want 00000000_002dc6c0", mul_if.hi, mul_if.lo);
        end
        mul_if.start     = 1'b1;
        mul_if.is_signed = 1'b1;
        mul_if.operand_a = 32'hFFFF_FFFE;
        mul_if.operand_b = 32'd3;
        @(posedge clk); #1;
        mul_if.start = 1'b0;
        tests_run++;
        if (mul_if.busy !== 1'b1 || mul_if.lo !== 32'd3000000) begin
            tests_failed++;
            $display("FAIL start_in_done_cycle got busy=%b lo=%h want 1 002dc6c0", mul_if.busy, mul_if.lo);
        end
        cyc = 0;
        while (mul_if.done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if ({mul_if.hi, mul_if.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA} || cyc !== 33) begin
            tests_failed++;
            $display("FAIL second_op got %h_%h at %0d want ffffffff_fffffffa at 33",
                     mul_if.hi, mul_if.lo, cyc);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] h, l;
        int cyc;
        int done_seen;
        mul_if.is_signed = 1'b1;
        mul_if.operand_a = 32'd7;
        mul_if.operand_b = 32'd9;
        mul_if.start     = 1'b1;
        @(posedge clk); #1;
        mul_if.start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({mul_if.busy, mul_if.done, mul_if.hi, mul_if.lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_abort got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     mul_if.busy, mul_if.done, mul_if.hi, mul_if.lo);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (mul_if.done === 1'b1 || mul_if.busy === 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen !== 0) begin
            tests_failed++;
            $display("FAIL no_done_after_abort got %0d active cycles want 0", done_seen);
        end
        run_op(1'b1, 32'd7, 32'd9, h, l, cyc);
        tests_run++;
        if ({h, l} !== {32'd0, 32'd63}) begin
            tests_failed++;
            $display("FAIL mult_7x9_after_reset got %h_%h want 00000000_0000003f", h, l);
        end
    endtask

    task automatic test_zero_and_random();
        logic [31:0] h, l, a, b;
        logic [63:0] want;
        logic sgn;
        int cyc;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd0, h, l, cyc);
        tests_run++;
        if ({h, l} !== 64'd0) begin
            tests_failed++;
            $display("FAIL mult_neg7x0 got %h_%h want 0_0", h, l);
        end
        for (int i = 0; i < 1000; i++) begin
            a   = $urandom;
            b   = $urandom;
            sgn = 1'($urandom_range(1, 0));
            if (sgn) begin
                want = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            end else begin
                want = {32'd0, a} * {32'd0, b};
            end
            run_op(sgn, a, b, h, l, cyc);
            tests_run++;
            if ({h, l} !== want || cyc !== 33) begin
                tests_failed++;
                $display("FAIL random_%0d s=%b a=%h b=%h got %h_%h at %0d want %h at 33",
                         i, sgn, a, b, h, l, cyc, want);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_multu_max();
        test_signed();
        test_back_to_back();
        test_reset_abort();
        test_zero_and_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
